mux_rr_arbiter: RTL

Round-robin arbiter that shares the 8-bit 2:1 mux datapath between two requesters, A and B. Each requester and the single output use a valid/ready stream interface. The block owns the mux select, holds the grant for a burst, and registers the selected data into one output pipeline stage. It sits directly in front of the mux consumer and replaces the free-running sel_i stimulus with sequenced control.

---
 rtl/mux_rr_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter in front of an 8-bit 2:1 mux: sequences the mux select,
// holds a grant for a burst of up to MAX_BURST beats and registers the chosen beat.
module mux_rr_arbiter #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  input  logic              a_last_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  input  logic              b_last_i,
  output logic              b_ready_o,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  output logic              y_last_o,
  input  logic              y_ready_i,
  output logic              sel_o,
  output logic              busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_A = 2'd1;
  localparam logic [1:0] ST_GNT_B = 2'd2;

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        burst_cnt_q, burst_cnt_d;
  logic              last_grant_q, last_grant_d;  // 1 = B was granted last
  logic              sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              y_valid_q, y_valid_d;
  logic [DATA_W-1:0] y_data_q, y_data_d;
  logic              y_last_q, y_last_d;

  logic              out_free_s;
  logic              grant_a_s;
  logic              grant_b_s;
  logic              g_valid_s;
  logic [DATA_W-1:0] g_data_s;
  logic              g_last_s;
  logic              other_valid_s;
  logic              accept_s;
  logic              burst_end_s;

  // Granted-requester view of the handshake and burst-end detection.
  always_comb begin
    out_free_s    = !y_valid_q || y_ready_i;
    grant_a_s     = (state_q == ST_GNT_A);
    grant_b_s     = (state_q == ST_GNT_B);
    if (grant_b_s) begin
      g_valid_s     = b_valid_i;
      g_data_s      = b_data_i;
      g_last_s      = b_last_i;
      other_valid_s = a_valid_i;
    end else begin
      g_valid_s     = a_valid_i;
      g_data_s      = a_data_i;
      g_last_s      = a_last_i;
      other_valid_s = b_valid_i;
    end
    accept_s    = (grant_a_s || grant_b_s) && g_valid_s && out_free_s;
    burst_end_s = accept_s && (g_last_s || (burst_cnt_q == CNT_LAST));
  end

  assign a_ready_o = grant_a_s && out_free_s;
  assign b_ready_o = grant_b_s && out_free_s;

  // Grant FSM: arbitration in IDLE and at every burst end, burst counting in between.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (a_valid_i && (!b_valid_i || last_grant_q)) begin
          state_d      = ST_GNT_A;
          burst_cnt_d  = 4'd0;
          last_grant_d = 1'b0;
          sel_d        = 1'b0;
        end else if (b_valid_i) begin
          state_d      = ST_GNT_B;
          burst_cnt_d  = 4'd0;
          last_grant_d = 1'b1;
          sel_d        = 1'b1;
        end else begin
          state_d      = ST_IDLE;
        end
      end
      ST_GNT_A, ST_GNT_B: begin
        if (burst_end_s) begin
          burst_cnt_d = 4'd0;
          // A natural last closes the requester's burst; only a forced end re-grants it.
          if (other_valid_s) begin
            state_d      = grant_a_s ? ST_GNT_B : ST_GNT_A;
            last_grant_d = grant_a_s;
            sel_d        = grant_a_s;
          end else if (g_valid_s && !g_last_s) begin
            state_d      = state_q;
          end else begin
            state_d      = ST_IDLE;
          end
        end else if (accept_s) begin
          burst_cnt_d = burst_cnt_q + 4'd1;
        end else begin
          burst_cnt_d = burst_cnt_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        burst_cnt_d = 4'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Output stage: load on accept, drain when consumed, hold while stalled.
  always_comb begin
    y_valid_d = y_valid_q;
    y_data_d  = y_data_q;
    y_last_d  = y_last_q;
    if (accept_s) begin
      y_valid_d = 1'b1;
      y_data_d  = g_data_s;
      y_last_d  = g_last_s || (burst_cnt_q == CNT_LAST);
    end else if (y_ready_i) begin
      y_valid_d = 1'b0;
    end else begin
      y_valid_d = y_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      burst_cnt_q  <= 4'd0;
      last_grant_q <= 1'b1;
      sel_q        <= 1'b0;
      busy_q       <= 1'b0;
      y_valid_q    <= 1'b0;
      y_data_q     <= {DATA_W{1'b0}};
      y_last_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      busy_q       <= busy_d;
      y_valid_q    <= y_valid_d;
      y_data_q     <= y_data_d;
      y_last_q     <= y_last_d;
    end
  end

  assign y_valid_o = y_valid_q;
  assign y_data_o  = y_data_q;
  assign y_last_o  = y_last_q;
  assign sel_o     = sel_q;
  assign busy_o    = busy_q;

endmodule
